seq_mul: RTL and testbench
==========================

// Module: seq_mul
//
// PURPOSE
// - Iterative radix-2 shift-add multiplier, DWIDTH x DWIDTH -> 2*DWIDTH, signed or unsigned.
// - Execute-stage unit; its product is captured by the downstream result register stage.
// - valid/ready on both sides; fixed latency of DWIDTH cycles; one operation in flight.
//
// PARAMETERS
// - DWIDTH   32   operand width; product is 2*DWIDTH; DWIDTH >= 2
//
// PORTS
// - clk          in   1         clock, all state updates on rising edge
// - rst          in   1         reset, synchronous, active-high
// - in_valid_i   in   1         operands valid
// - in_ready_o   out  1         unit accepts operands (high only in IDLE)
// - op_a_i       in   DWIDTH    multiplicand
// - op_b_i       in   DWIDTH    multiplier
// - signed_i     in   1         1: both operands two's complement; 0: both unsigned
// - out_valid_o  out  1         product valid (high only in DONE)
// - out_ready_i  in   1         downstream consumes product
// - product_o    out  2*DWIDTH  registered product
// - busy_o       out  1         high in BUSY or DONE
//
// BEHAVIOUR
// - Reset: state=IDLE, in_ready_o=1, out_valid_o=0, busy_o=0, product_o=0, counter=0.
// - Reset has priority over every other event, including mid-BUSY and DONE; in-flight op is dropped.
// - FSM states:
//   - IDLE -> BUSY when in_valid_i && in_ready_o (accept edge).
//   - BUSY -> DONE on the edge where counter==0.
//   - DONE -> IDLE on the edge where out_ready_i==1.
// - Accept edge:
//   - Latch |a| and |b|; magnitudes apply when signed_i=1, else raw values.
//   - Latch neg = signed_i & (a[MSB] ^ b[MSB]); clear accumulator; counter <= DWIDTH-1.
// - Operands are sampled only on the accept edge; later input changes have no effect.
// - BUSY, per cycle:
//   - If the multiplier LSB is 1, add the shifted multiplicand to the 2*DWIDTH accumulator.
//   - Shift multiplicand left and multiplier right; decrement counter.
// - DONE entry edge: product_o <= neg ? -acc : acc. No wrap: |min|*|min| = 2^(2*DWIDTH-2) fits.
// - Latency: accept at edge k -> out_valid_o high in the cycle after edge k+DWIDTH.
// - No early exit on zero operands; latency is identical for all inputs.
// - Handshake rules:
//   - product_o is stable while out_valid_o=1 && out_ready_i=0; hold indefinitely.
//   - in_valid_i during BUSY/DONE is ignored; in_ready_o=0 there.
//   - out_ready_i outside DONE is ignored.
// - Throughput: one op per DWIDTH+2 cycles minimum (accept, DWIDTH BUSY, 1 DONE).
// - product_o keeps its last value in IDLE/BUSY until overwritten on the next DONE entry.
//
// STRUCTURE
// - Package mul_pkg:
//   - typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_e;
//   - function cnt_w(DWIDTH) = $clog2(DWIDTH).
// - Sub-module mul_fsm: state register, counter, handshake outputs.
// - Datapath (operand/accumulator registers, adder, negate) stays in seq_mul.
// - All registers use synchronous reset.
//
// TESTING (DWIDTH=32)
// - Unsigned 3*5 -> product 0x0000_0000_0000_000F; out_valid exactly 32 cycles after accept.
// - Signed -3 (0xFFFFFFFD) * 5 -> 0xFFFF_FFFF_FFFF_FFF1; signed 0x80000000^2 -> 0x4000_0000_0000_0000.
// - Unsigned 0xFFFFFFFF^2 -> 0xFFFF_FFFE_0000_0001; signed 0xFFFFFFFF^2 (-1*-1) -> 0x1.
// - out_ready_i=0 for 10 cycles in DONE -> product_o/out_valid_o held; in_ready_o=0; new in_valid_i ignored.
// - rst asserted at BUSY cycle 16 -> next cycle IDLE, outputs at reset values; next op correct.
// - Back-to-back: out_ready_i=1 and in_valid_i=1 always -> accepts spaced 34 cycles; all products correct.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  function automatic int unsigned cnt_w(input int unsigned dwidth);
    return $clog2(dwidth);
  endfunction

endpackage

// File: rtl/mul_fsm.sv
// Control for seq_mul: state register, iteration counter and handshake outputs.
module mul_fsm
  import mul_pkg::*;
#(
  parameter int unsigned DWIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid_i,
  input  logic out_ready_i,
  output logic in_ready_o,
  output logic out_valid_o,
  output logic busy_o,
  output logic accept_o,
  output logic step_o,
  output logic finish_o
);

  localparam int unsigned CntW = cnt_w(DWIDTH);

  mul_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q;

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q == BUSY) || (state_q == DONE);
  assign accept_o    = in_ready_o && in_valid_i;
  assign step_o      = (state_q == BUSY);
  // Last iteration: the datapath folds this step into the captured product.
  assign finish_o    = step_o && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept_o) state_d = BUSY;
      BUSY:    if (finish_o) state_d = DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept_o) begin
        cnt_q <= CntW'(DWIDTH - 1);
      end else if (step_o && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_mul.sv
// Radix-2 shift-add multiplier, DWIDTH x DWIDTH -> 2*DWIDTH, signed or unsigned.
module seq_mul
  import mul_pkg::*;
#(
  parameter int unsigned DWIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [DWIDTH-1:0]   op_a_i,
  input  logic [DWIDTH-1:0]   op_b_i,
  input  logic                signed_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [2*DWIDTH-1:0] product_o,
  output logic                busy_o
);

  localparam int unsigned PW = 2 * DWIDTH;

  logic              accept, step, finish;
  logic [DWIDTH-1:0] mag_a, mag_b;
  logic [PW-1:0]     mcand_q;
  logic [DWIDTH-1:0] mplier_q;
  logic [PW-1:0]     acc_q, acc_step;
  logic              neg_q;
  logic [PW-1:0]     product_q;

  mul_fsm #(
    .DWIDTH(DWIDTH)
  ) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid_i),
    .out_ready_i(out_ready_i),
    .in_ready_o (in_ready_o),
    .out_valid_o(out_valid_o),
    .busy_o     (busy_o),
    .accept_o   (accept),
    .step_o     (step),
    .finish_o   (finish)
  );

  // Signed operands are reduced to magnitudes; the sign is reapplied at the end.
  assign mag_a    = (signed_i && op_a_i[DWIDTH-1]) ? -op_a_i : op_a_i;
  assign mag_b    = (signed_i && op_b_i[DWIDTH-1]) ? -op_b_i : op_b_i;
  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      if (accept) begin
        mcand_q  <= {{DWIDTH{1'b0}}, mag_a};
        mplier_q <= mag_b;
        acc_q    <= '0;
        neg_q    <= signed_i && (op_a_i[DWIDTH-1] ^ op_b_i[DWIDTH-1]);
      end else if (step) begin
        acc_q    <= acc_step;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
      end
      if (finish) begin
        product_q <= neg_q ? -acc_step : acc_step;
      end
    end
  end

  assign product_o = product_q;

endmodule

// File: tb/tb_seq_mul.sv
// Scoreboard bench for seq_mul: driver pushes expected products, monitor pops and compares.
module tb_seq_mul;

  localparam int unsigned W   = 32;
  localparam int          LAT = 32;

  logic          clk, rst;
  logic          in_valid, in_ready, signed_in, out_valid, out_ready, busy;
  logic [W-1:0]  op_a, op_b;
  logic [63:0]   product;

  typedef struct {
    logic [63:0] prod;
    int          acc_edge;
  } exp_t;

  exp_t q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   cyc       = 0;

  seq_mul #(
    .DWIDTH(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .op_a_i     (op_a),
    .op_b_i     (op_b),
    .signed_i   (signed_in),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .product_o  (product),
    .busy_o     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain full-width integer multiply.
  function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  // Monitor: latency on valid rise, product on each consumed output.
  initial begin
    logic prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_output", 64'(out_valid), 64'd0);
        end else begin
          if (!prev_valid) check("latency", 64'(cyc - q[0].acc_edge), 64'(LAT));
          if (out_ready) begin
            check("product", product, q[0].prod);
            void'(q.pop_front());
          end
        end
      end
      prev_valid = out_valid;
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [63:0] exp);
    exp_t e;
    bit   got;
    got = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; op_a = a; op_b = b; signed_in = s;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.prod = exp; e.acc_edge = cyc + 1;
        q.push_back(e);
        got = 1'b1;
        break;
      end
    end
    if (!got) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom); signed_in = 1'($urandom);
  endtask

  task automatic drain(input int maxcyc, input bit rnd);
    for (int i = 0; i < maxcyc; i++) begin
      @(posedge clk); #1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (q.size() == 0) break;
    end
    if (q.size() != 0) check("drain_timeout", 64'(q.size()), 64'd0);
    out_ready = 1'b1;
  endtask

  initial begin
    logic [63:0] held;
    logic [W-1:0] a, b;
    logic         s;
    int           last, n;

    rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; signed_in = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_product", product, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    issue(32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F);
    drain(100, 1'b0);
    issue(32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
    drain(100, 1'b0);
    issue(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    drain(100, 1'b0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    drain(100, 1'b0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
    drain(100, 1'b0);
    issue(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, ref_mul(32'h8000_0000, 32'h7FFF_FFFF, 1'b1));
    drain(100, 1'b0);

    // Hold product in DONE while downstream stalls; new requests must be ignored.
    out_ready = 1'b0;
    issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, ref_mul(32'h1234_5678, 32'h9ABC_DEF0, 1'b0));
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    check("hold_reached_done", 64'(out_valid), 64'd1);
    held = product;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; op_a = W'($urandom); op_b = W'($urandom);
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_product", product, held);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    drain(10, 1'b0);
    repeat (40) @(negedge clk);
    check("hold_no_extra", 64'(busy), 64'd0);

    // Reset in the middle of BUSY drops the operation.
    issue(32'd77, 32'd99, 1'b0, ref_mul(32'd77, 32'd99, 1'b0));
    @(negedge clk);
    check("busy_flag", 64'(busy), 64'd1);
    check("busy_in_ready", 64'(in_ready), 64'd0);
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_product", product, 64'd0);
    issue(32'hDEAD_BEEF, 32'hFFFF_FF00, 1'b1, ref_mul(32'hDEAD_BEEF, 32'hFFFF_FF00, 1'b1));
    drain(100, 1'b0);

    // Back-to-back: in_valid and out_ready held high.
    out_ready = 1'b1;
    @(posedge clk); #1;
    a = W'($urandom); b = W'($urandom); s = 1'($urandom);
    in_valid = 1'b1; op_a = a; op_b = b; signed_in = s;
    last = 0; n = 0;
    for (int i = 0; i < 400 && n < 6; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_t e;
        e.prod = ref_mul(a, b, s); e.acc_edge = cyc + 1;
        q.push_back(e);
        if (n > 0) check("b2b_spacing", 64'(cyc + 1 - last), 64'(W + 2));
        last = cyc + 1;
        n++;
        @(posedge clk); #1;
        a = W'($urandom); b = W'($urandom); s = 1'($urandom);
        op_a = a; op_b = b; signed_in = s;
      end
    end
    check("b2b_count", 64'(n), 64'd6);
    in_valid = 1'b0;
    drain(100, 1'b0);

    // Random operands with random downstream stalls.
    for (int i = 0; i < 15; i++) begin
      a = (i % 5 == 0) ? 32'h0 : W'($urandom);
      b = (i % 7 == 3) ? 32'h8000_0000 : W'($urandom);
      s = 1'($urandom);
      issue(a, b, s, ref_mul(a, b, s));
      drain(300, 1'b1);
    end

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
